// File: rtl/calc_g_sweep_ctrl_pkg.sv
// Shared constants, types and helpers for the calc_G sweep controller.
package calc_g_sweep_ctrl_pkg;

    localparam int COORD_W = 10;
    localparam int Z_W     = 32;
    localparam int G_W     = 16;
    localparam int RES_W   = 2 * COORD_W + 2 * G_W;

    localparam logic signed [COORD_W-1:0] COORD_ONE = 10'sd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Tag travelling alongside a datapath request until its result appears.
    typedef struct packed {
        logic                      valid;
        logic signed [COORD_W-1:0] m;
        logic signed [COORD_W-1:0] n;
    } tag_t;

    // Result record layout, most significant first: m, n, G_re, G_im.
    function automatic logic [RES_W-1:0] pack_result(
        input logic [COORD_W-1:0] m,
        input logic [COORD_W-1:0] n,
        input logic [G_W-1:0]     re,
        input logic [G_W-1:0]     im
    );
        return {m, n, re, im};
    endfunction

endpackage

// File: rtl/calc_g_sweep_ctrl_if.sv
// Datapath request/response bus and downstream result stream.
interface calc_g_sweep_ctrl_if;
    import calc_g_sweep_ctrl_pkg::*;

    logic signed [COORD_W-1:0] dp_m;
    logic signed [COORD_W-1:0] dp_n;
    logic        [Z_W-1:0]     dp_zparam;
    logic        [G_W-1:0]     dp_g_re;
    logic        [G_W-1:0]     dp_g_im;

    logic                      out_valid;
    logic                      out_ready;
    logic signed [COORD_W-1:0] out_m;
    logic signed [COORD_W-1:0] out_n;
    logic        [G_W-1:0]     out_re;
    logic        [G_W-1:0]     out_im;

    modport master (
        output dp_m, dp_n, dp_zparam,
        input  dp_g_re, dp_g_im,
        output out_valid, out_m, out_n, out_re, out_im,
        input  out_ready
    );

    modport slave (
        input  dp_m, dp_n, dp_zparam,
        output dp_g_re, dp_g_im,
        input  out_valid, out_m, out_n, out_re, out_im,
        output out_ready
    );

endinterface

// File: rtl/calc_g_sweep_ctrl_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count and flush.
// Read data is forced to zero while empty so the stream idles at zero.
module calc_g_sweep_ctrl_result_fifo
    import calc_g_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = (count_r != {CW{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign count   = count_r;

endmodule

// File: rtl/calc_g_sweep_ctrl.sv
// Sweeps calc_G_top over an inclusive (m,n) grid for one latched zparam,
// tags every request, captures results after G_LATENCY cycles and streams
// them out through a credit-protected FWFT FIFO (n is the inner loop).
// Optional build macro CALC_G_ABORT_EN adds an abort input that flushes
// everything in flight and ends the sweep with a done pulse.
module calc_g_sweep_ctrl
    import calc_g_sweep_ctrl_pkg::*;
#(
    parameter int G_LATENCY  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef CALC_G_ABORT_EN
    input  logic                      abort,
`endif
    input  logic                      start,
    input  logic        [Z_W-1:0]     zparam_in,
    input  logic signed [COORD_W-1:0] m_min,
    input  logic signed [COORD_W-1:0] m_max,
    input  logic signed [COORD_W-1:0] n_min,
    input  logic signed [COORD_W-1:0] n_max,
    output logic                      busy,
    output logic                      done,
    output logic                      range_err,
    calc_g_sweep_ctrl_if.master       bus
);

    localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

    state_t                    state_r, state_s;
    logic signed [COORD_W-1:0] m_cur_r, n_cur_r, m_max_r, n_min_r, n_max_r;
    logic        [Z_W-1:0]     zparam_r;
    tag_t                      tag_pipe_r [G_LATENCY];
    tag_t                      tag_out_s;
    logic        [CNT_W-1:0]   reserved_r, reserved_s, fifo_count_s;
    logic                      busy_r, done_r, range_err_r;
    logic                      range_ok_s, accept_s, issue_s, at_end_s;
    logic                      pop_s, abort_s, done_s, drain_empty_s, out_valid_s;
    logic        [RES_W-1:0]   wr_data_s, rd_data_s;

`ifdef CALC_G_ABORT_EN
    assign abort_s = abort && (state_r != IDLE);
`else
    assign abort_s = 1'b0;
`endif

    assign range_ok_s    = (m_min <= m_max) && (n_min <= n_max);
    assign accept_s      = (state_r == IDLE) && start && range_ok_s;
    assign at_end_s      = (m_cur_r == m_max_r) && (n_cur_r == n_max_r);
    assign tag_out_s     = tag_pipe_r[G_LATENCY-1];
    assign out_valid_s   = (fifo_count_s != {CNT_W{1'b0}});
    assign pop_s         = out_valid_s && bus.out_ready;
    // Nothing in flight and the last FIFO entry (if any) leaves this cycle.
    assign drain_empty_s = (reserved_r == {CNT_W{1'b0}}) ||
                           ((reserved_r == CNT_W'(1)) && pop_s);
    assign done_s        = ((state_r == DRAIN) && drain_empty_s) || abort_s;

    // Next-state and issue decision; an issue needs a free FIFO credit.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SWEEP;
                end else begin
                    state_s = IDLE;
                end
            end
            SWEEP: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else if (reserved_r < DEPTH_C) begin
                    issue_s = 1'b1;
                    if (at_end_s) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = SWEEP;
                    end
                end else begin
                    state_s = SWEEP;
                end
            end
            DRAIN: begin
                if (done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Credits: points in flight plus points waiting in the FIFO.
    always_comb begin
        if (abort_s) begin
            reserved_s = {CNT_W{1'b0}};
        end else begin
            reserved_s = reserved_r + CNT_W'(issue_s) - CNT_W'(pop_s);
        end
    end

    // Control state, credit counter and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            reserved_r  <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            range_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            reserved_r  <= reserved_s;
            busy_r      <= (state_s != IDLE);
            done_r      <= done_s;
            range_err_r <= (state_r == IDLE) && start && !range_ok_s;
        end
    end

    // Sweep bounds and cursor; the cursor is compared before it is
    // incremented so a bound of +511 never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            zparam_r <= {Z_W{1'b0}};
            m_max_r  <= {COORD_W{1'b0}};
            n_min_r  <= {COORD_W{1'b0}};
            n_max_r  <= {COORD_W{1'b0}};
            m_cur_r  <= {COORD_W{1'b0}};
            n_cur_r  <= {COORD_W{1'b0}};
        end else if (accept_s) begin
            zparam_r <= zparam_in;
            m_max_r  <= m_max;
            n_min_r  <= n_min;
            n_max_r  <= n_max;
            m_cur_r  <= m_min;
            n_cur_r  <= n_min;
        end else if (issue_s && !at_end_s) begin
            if (n_cur_r == n_max_r) begin
                n_cur_r <= n_min_r;
                m_cur_r <= m_cur_r + COORD_ONE;
            end else begin
                n_cur_r <= n_cur_r + COORD_ONE;
            end
        end
    end

    // Tag delay line aligned with the datapath latency; abort kills all tags.
    always_ff @(posedge clk) begin
        if (rst || abort_s) begin
            for (int i = 0; i < G_LATENCY; i++) begin
                tag_pipe_r[i] <= '0;
            end
        end else begin
            tag_pipe_r[0] <= '{valid: issue_s, m: m_cur_r, n: n_cur_r};
            for (int i = 1; i < G_LATENCY; i++) begin
                tag_pipe_r[i] <= tag_pipe_r[i-1];
            end
        end
    end

    assign wr_data_s = pack_result(tag_out_s.m, tag_out_s.n, bus.dp_g_re, bus.dp_g_im);

    calc_g_sweep_ctrl_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort_s),
        .wr_en   (tag_out_s.valid),
        .wr_data (wr_data_s),
        .rd_en   (pop_s),
        .rd_data (rd_data_s),
        .count   (fifo_count_s)
    );

    assign bus.dp_m      = m_cur_r;
    assign bus.dp_n      = n_cur_r;
    assign bus.dp_zparam = zparam_r;
    assign bus.out_valid = out_valid_s;
    assign {bus.out_m, bus.out_n, bus.out_re, bus.out_im} = rd_data_s;

    assign busy      = busy_r;
    assign done      = done_r;
    assign range_err = range_err_r;

endmodule

// File: tb/tb_calc_g_sweep_ctrl.sv
// Scoreboard bench for calc_g_sweep_ctrl with a stub datapath.
module tb_calc_g_sweep_ctrl;
    import calc_g_sweep_ctrl_pkg::*;

    localparam int G_LAT = 8;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [31:0]        zparam_in = 32'h0;
    logic signed [9:0]  m_min = 10'sd0, m_max = 10'sd0, n_min = 10'sd0, n_max = 10'sd0;
    logic               busy, done, range_err;
    logic               out_ready = 1'b1;
    int                 ready_mode = 1;
    bit                 skip_hold = 1'b0;
`ifdef CALC_G_ABORT_EN
    logic               abort = 1'b0;
`endif

    calc_g_sweep_ctrl_if bus();

    calc_g_sweep_ctrl #(.G_LATENCY(G_LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CALC_G_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .zparam_in (zparam_in),
        .m_min     (m_min),
        .m_max     (m_max),
        .n_min     (n_min),
        .n_max     (n_max),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Stub datapath: G_re={m[7:0],n[7:0]}, G_im=z[15:0]^{n[7:0],m[7:0]}, G_LAT deep.
    logic [15:0] st_re [G_LAT];
    logic [15:0] st_im [G_LAT];
    always @(posedge clk) begin
        st_re[0] <= {bus.dp_m[7:0], bus.dp_n[7:0]};
        st_im[0] <= bus.dp_zparam[15:0] ^ {bus.dp_n[7:0], bus.dp_m[7:0]};
        for (int i = 1; i < G_LAT; i++) begin
            st_re[i] <= st_re[i-1];
            st_im[i] <= st_im[i-1];
        end
    end
    assign bus.dp_g_re   = st_re[G_LAT-1];
    assign bus.dp_g_im   = st_im[G_LAT-1];
    assign bus.out_ready = out_ready;

    // Downstream ready pattern.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    typedef struct packed {
        logic [9:0]  m;
        logic [9:0]  n;
        logic [15:0] re;
        logic [15:0] im;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_rcv  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every grid point, m-major then n-minor.
    task automatic push_sweep(input int mlo, input int mhi, input int nlo, input int nhi,
                              input logic [31:0] z);
        exp_t e;
        logic [31:0] mv, nv;
        for (int m = mlo; m <= mhi; m++) begin
            for (int n = nlo; n <= nhi; n++) begin
                mv   = m;
                nv   = n;
                e.m  = mv[9:0];
                e.n  = nv[9:0];
                e.re = {mv[7:0], nv[7:0]};
                e.im = z[15:0] ^ {nv[7:0], mv[7:0]};
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: pops and compares on each handshake, checks hold stability.
    exp_t held;
    bit   hold_v = 1'b0;
    always @(negedge clk) begin
        exp_t got;
        got = {bus.out_m, bus.out_n, bus.out_re, bus.out_im};
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && !skip_hold) begin
                check("hold_stable", {bus.out_valid, got}, {1'b1, held});
            end
            if (bus.out_valid && bus.out_ready) begin
                n_rcv++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", got, 64'h0);
                end else begin
                    check("result", got, exp_q.pop_front());
                end
                hold_v = 1'b0;
            end else if (bus.out_valid) begin
                hold_v = 1'b1;
                held   = got;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic do_start(input int mlo, input int mhi, input int nlo, input int nhi,
                            input logic [31:0] z);
        @(posedge clk);
        #1;
        m_min     = 10'(mlo);
        m_max     = 10'(mhi);
        n_min     = 10'(nlo);
        n_max     = 10'(nhi);
        zparam_in = z;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Waits for done; cyc = rising edges since the start edge.
    task automatic wait_done(input int budget, output int cyc, output bit busy_ok);
        bit seen = 1'b0;
        cyc     = 0;
        busy_ok = 1'b1;
        while (!seen && cyc <= budget) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                cyc++;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rcv0, mlo, mhi, nlo, nhi;
        bit bok;
        logic [31:0] z;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_range_err", 64'(range_err), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_dp_mn", {bus.dp_m, bus.dp_n}, 64'd0);
        check("rst_dp_zparam", 64'(bus.dp_zparam), 64'd0);
        check("rst_out_data", {bus.out_m, bus.out_n, bus.out_re, bus.out_im}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic 3x2 sweep, ready always high, minimum latency
        ready_mode = 1;
        rcv0 = n_rcv;
        push_sweep(-1, 1, 0, 1, 32'h3F800000);
        do_start(-1, 1, 0, 1, 32'h3F800000);
        wait_done(200, cyc, bok);
        check("t1_latency", 64'(cyc), 64'(6 + G_LAT + 1));
        check("t1_busy_throughout", 64'(bok), 64'd1);
        check("t1_count", 64'(n_rcv - rcv0), 64'd6);
        check("t1_dp_zparam", 64'(bus.dp_zparam), 64'h3F800000);
        @(negedge clk);
        check("t1_done_pulse_width", 64'(done), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // 10x10 sweep with downstream stalled for 100 cycles
        rcv0 = n_rcv;
        ready_mode = 0;
        push_sweep(-5, 4, -3, 6, 32'h12345678);
        do_start(-5, 4, -3, 6, 32'h12345678);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("stall_cursor_m", 64'(bus.dp_m), 64'(-4));
        check("stall_cursor_n", 64'(bus.dp_n), 64'(3));
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_head", {bus.out_m, bus.out_n}, {10'(-5), 10'(-3)});
        check("stall_none_out", 64'(n_rcv - rcv0), 64'd0);
        @(posedge clk);
        #1 ready_mode = 2;
        wait_done(4000, cyc, bok);
        check("stall_count", 64'(n_rcv - rcv0), 64'd100);
        check("stall_q_empty", 64'(exp_q.size()), 64'd0);

        // Rejected ranges
        ready_mode = 1;
        do_start(3, 2, 0, 1, 32'hDEADBEEF);
        @(negedge clk);
        check("rerr_m_pulse", 64'(range_err), 64'd1);
        check("rerr_m_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("rerr_pulse_width", 64'(range_err), 64'd0);
        check("rerr_dp_unchanged", {bus.dp_m, bus.dp_n}, {10'(4), 10'(6)});
        check("rerr_zp_unchanged", 64'(bus.dp_zparam), 64'h12345678);
        do_start(0, 1, 5, -5, 32'h0);
        @(negedge clk);
        check("rerr_n_pulse", {range_err, busy}, {1'b1, 1'b0});

        // Single point at +511 with an ignored start while busy
        rcv0 = n_rcv;
        push_sweep(511, 511, 511, 511, 32'hCAFE0001);
        do_start(511, 511, 511, 511, 32'hCAFE0001);
        do_start(0, 3, 0, 3, 32'h0);
        wait_done(100, cyc, bok);
        check("p511_count", 64'(n_rcv - rcv0), 64'd1);
        check("p511_dp", {bus.dp_m, bus.dp_n}, {10'(511), 10'(511)});
        repeat (20) @(negedge clk);
        check("p511_no_restart", {busy, bus.out_valid}, 64'd0);
        check("p511_count_after", 64'(n_rcv - rcv0), 64'd1);

        // Random ranges, zparam and back-pressure
        ready_mode = 2;
        for (int it = 0; it < 4; it++) begin
            mlo = $urandom_range(0, 8) - 4;
            mhi = mlo + $urandom_range(0, 4);
            nlo = $urandom_range(0, 8) - 4;
            nhi = nlo + $urandom_range(0, 5);
            z   = $urandom;
            rcv0 = n_rcv;
            push_sweep(mlo, mhi, nlo, nhi, z);
            do_start(mlo, mhi, nlo, nhi, z);
            wait_done(1500, cyc, bok);
            check("rand_count", 64'(n_rcv - rcv0), 64'((mhi - mlo + 1) * (nhi - nlo + 1)));
        end

        // Reset in the middle of a sweep, then a clean sweep
        ready_mode = 1;
        rcv0 = n_rcv;
        do_start(0, 3, 0, 3, 32'h55AA55AA);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_status", {busy, done, range_err, bus.out_valid}, 64'd0);
        check("mrst_dp", {bus.dp_m, bus.dp_n, bus.dp_zparam}, 64'd0);
        check("mrst_none_out", 64'(n_rcv - rcv0), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rcv0 = n_rcv;
        push_sweep(-2, 0, 1, 2, 32'h0BADF00D);
        do_start(-2, 0, 1, 2, 32'h0BADF00D);
        wait_done(200, cyc, bok);
        check("mrst_after_count", 64'(n_rcv - rcv0), 64'd6);
        check("mrst_after_latency", 64'(cyc), 64'(6 + G_LAT + 1));

`ifdef CALC_G_ABORT_EN
        // Abort while the FIFO holds results
        ready_mode = 0;
        rcv0 = n_rcv;
        do_start(0, 4, 0, 4, 32'h1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("abort_pre_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1 abort = 1'b1;
        skip_hold = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_state", {bus.out_valid, done, busy}, {1'b0, 1'b1, 1'b0});
        skip_hold = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_quiet", {bus.out_valid, busy, done}, 64'd0);
        check("abort_none_out", 64'(n_rcv - rcv0), 64'd0);
        ready_mode = 1;
`endif

        repeat (5) @(negedge clk);
        check("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_g_sweep_ctrl.md
Name: calc_G_sweep_ctrl

Overview:
- Sequences the calc_G_top datapath over a rectangular (m,n) grid for one latched zparam.
- Tags each issued point, captures G_re/G_im after the fixed pipeline latency, and buffers results in a FIFO.
- Streams (m, n, G_re, G_im) downstream over a valid/ready handshake.
- Sits between the host/config logic and calc_G_top, replacing the free-running tie-offs on m, n and zparam.

Parameters:
- G_LATENCY, 8, cycles from m/n/zparam presented to matching G_re/G_im valid at datapath output (≥1).
- FIFO_DEPTH, 16, result FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- zparam_in  in  32  z parameter, latched at accepted start
- m_min, m_max  in  10 signed  m range, inclusive, latched at start
- n_min, n_max  in  10 signed  n range, inclusive, latched at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last result is handed off
- range_err  out  1  one-cycle pulse: start rejected (m_min>m_max or n_min>n_max)
- dp_m, dp_n  out  10 signed  to calc_G_top m, n
- dp_zparam  out  32  to calc_G_top zparam
- dp_G_re, dp_G_im  in  16  from calc_G_top
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_m, out_n  out  10 signed  coordinates of result
- out_re, out_im  out  16  G result

Behaviour:
- Reset: state IDLE; busy=0, done=0, range_err=0, out_valid=0; dp_m=0, dp_n=0, dp_zparam=0; out_* data=0; FIFO and counters cleared; tag pipeline cleared.
- FSM:
  - IDLE: start with valid range → latch bounds and zparam, load m=m_min, n=n_min → SWEEP. Start with invalid range → range_err pulse, stay IDLE. Start outside IDLE is ignored.
  - SWEEP: issue allowed when reserved < FIFO_DEPTH.
    - On issue: present the cursor on dp_m/dp_n, push tag {1,m,n} into a G_LATENCY-deep delay line, reserved+1.
    - n is the inner loop: n==n_max → n=n_min, m+1.
    - Issue of (m_max, n_max) → DRAIN.
    - No issue this cycle → push tag valid=0.
  - DRAIN: no issues; tags keep shifting. When delay line is empty and FIFO is empty → done pulse, → IDLE.
- Capture: tag leaving delay line with valid=1 writes {m, n, dp_G_re, dp_G_im} into the FIFO in that cycle.
- Credit accounting:
  - reserved counts in-flight points plus FIFO entries; −1 on out_valid&&out_ready.
  - Guarantees the FIFO never overflows, since the datapath cannot stall.
  - Simultaneous issue and pop → reserved unchanged.
- Output:
  - out_valid = FIFO non-empty, first-word-fall-through.
  - Data stable while out_valid && !out_ready.
  - Order equals issue order: m-major, n-minor.
- dp_zparam holds the latched value through SWEEP/DRAIN and after return to IDLE.
- Arithmetic: signed 10-bit compare/increment; m_max=511 or n_max=511 must terminate without wrap (compare before increment).
- Single-point sweep (min==max on both axes): one issue, straight to DRAIN.
- Minimum sweep latency with out_ready=1: points + G_LATENCY + 1 cycles to done.
- rst mid-sweep: everything returns to reset values next edge; in-flight results are discarded; no done pulse.

Optional Feature:
- Macro: CALC_G_ABORT_EN.
- Enabled: adds input port abort (1 bit).
  - abort in SWEEP or DRAIN stops issuing immediately.
  - Marks all in-flight tags invalid and flushes the FIFO; out_valid=0 next cycle.
  - Clears reserved, pulses done, → IDLE.
  - abort in IDLE has no effect.
- Disabled: no port, no logic; sweep completes or rst is required.

Decomposition:
- Package calc_G_pkg:
  - Constants COORD_W=10, Z_W=32, G_W=16.
  - State enum IDLE/SWEEP/DRAIN.
  - Result record width RES_W = 2*COORD_W + 2*G_W = 52.
- Sub-module calc_G_result_fifo: synchronous FWFT FIFO, RES_W × FIFO_DEPTH, with count output.
- Tag delay line stays inline.

Test Plan:
- m∈[-1,1], n∈[0,1], zparam=0x3F800000, out_ready=1 → six results in order (-1,0),(-1,1),(0,0),(0,1),(1,0),(1,1); busy=1 throughout; done one cycle after last handshake; dp_zparam=0x3F800000.
- Stub datapath returning G_re={m[7:0],n[7:0]} delayed G_LATENCY → every out_re matches out_m/out_n.
- out_ready=0 for 100 cycles on a 10×10 sweep → issues stop at FIFO_DEPTH=16 reserved; no lost or duplicated points after release; all 100 results delivered.
- start with m_min=3, m_max=2 → range_err pulse, busy stays 0, no dp activity.
- m=n=511 single point → exactly one result, done, no wrap; start pulses during busy are ignored.
- rst asserted at cycle 5 of sweep → all outputs at reset values next cycle; new sweep then completes normally. With CALC_G_ABORT_EN: abort mid-sweep → out_valid=0 next cycle, done pulse, IDLE.
